// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the single-clock FIFO family
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_FIFO_DEPTH = 8;

    // Read-mode encodings for the FWFT parameter
    localparam int FWFT_REGISTERED = 0;
    localparam int FWFT_SHOWAHEAD  = 1;

    function automatic int fifo_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - register array, synchronous write, asynchronous read
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - single-clock FIFO with occupancy, thresholds, sticky errors,
// flush and optional first-word-fall-through read
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int  FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int  FWFT       = FWFT_REGISTERED,
    localparam int PTR_WIDTH  = fifo_clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_inc,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  r_inc,
    input  logic                  flush,
    input  logic                  err_clr,
    input  logic [PTR_WIDTH-1:0]  af_thresh,
    input  logic [PTR_WIDTH-1:0]  ae_thresh,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [PTR_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int ADDR_WIDTH = PTR_WIDTH - 1;

    logic [PTR_WIDTH-1:0]  wptr, rptr, wptr_next, rptr_next;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  wr_ok, rd_ok;

    // Flags come only from the registered count, never from the request inputs
    assign full         = (count == PTR_WIDTH'(FIFO_DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);

    assign wr_ok = w_inc && !full  && !flush;
    assign rd_ok = r_inc && !empty && !flush;

    always_comb begin
        wptr_next = wptr;
        rptr_next = rptr;
        if (flush) begin
            wptr_next = '0;
            rptr_next = '0;
        end else begin
            if (wr_ok) wptr_next = wptr + PTR_WIDTH'(1);
            if (rd_ok) rptr_next = rptr + PTR_WIDTH'(1);
        end
    end

    // The wrap bit makes the pointer difference an exact occupancy 0..FIFO_DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr_next;
            rptr  <= rptr_next;
            count <= wptr_next - rptr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_inc && full && !flush) overflow <= 1'b1;
            else if (err_clr)            overflow <= 1'b0;
            if (r_inc && empty && !flush) underflow <= 1'b1;
            else if (err_clr)             underflow <= 1'b0;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_addr (rptr[ADDR_WIDTH-1:0]),
        .rd_data (mem_rd_data)
    );

    generate
        if (FWFT == FWFT_SHOWAHEAD) begin : g_showahead
            assign rd_data  = mem_rd_data;
            assign rd_valid = !empty;
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_ok;
                    if (rd_ok) rd_data_q <= mem_rd_data;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb/tb_sync_fifo_flex.sv - scoreboard bench for sync_fifo_flex, registered and FWFT instances
module tb_sync_fifo_flex;

    localparam int DW = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n, w_inc, r_inc, flush, err_clr;
    logic [DW-1:0] wr_data;
    logic [PW-1:0] af_thresh, ae_thresh;

    logic [DW-1:0] rd_data_0, rd_data_1;
    logic [PW-1:0] count_0, count_1;
    logic          rd_valid_0, full_0, empty_0, af_0, ae_0, ovf_0, unf_0;
    logic          rd_valid_1, full_1, empty_1, af_1, ae_1, ovf_1, unf_1;

    int            n_chk  = 0;
    int            n_pass = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    sync_fifo_flex #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .FWFT(0)) dut_reg (
        .clk(clk), .rst_n(rst_n), .w_inc(w_inc), .wr_data(wr_data), .r_inc(r_inc),
        .flush(flush), .err_clr(err_clr), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .rd_data(rd_data_0), .rd_valid(rd_valid_0), .count(count_0), .full(full_0),
        .empty(empty_0), .almost_full(af_0), .almost_empty(ae_0),
        .overflow(ovf_0), .underflow(unf_0)
    );

    sync_fifo_flex #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .FWFT(1)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .w_inc(w_inc), .wr_data(wr_data), .r_inc(r_inc),
        .flush(flush), .err_clr(err_clr), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .rd_data(rd_data_1), .rd_valid(rd_valid_1), .count(count_1), .full(full_1),
        .empty(empty_1), .almost_full(af_1), .almost_empty(ae_1),
        .overflow(ovf_1), .underflow(unf_1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every registered-mode read result is matched against the queue
    always @(negedge clk) begin
        if (rst_n && rd_valid_0) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected_valid: got rd_data 0x%0h expected no valid", rd_data_0);
            end else begin
                check("sb_rd_data", rd_data_0, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; w_inc = 1'b0; r_inc = 1'b0; flush = 1'b0; err_clr = 1'b0;
        wr_data = '0; af_thresh = 4'd6; ae_thresh = 4'd1;
        step(); step();
        rst_n = 1'b1;
        step();

        check("rst_count", count_0, 0);
        check("rst_empty", empty_0, 1);
        check("rst_ae", ae_0, 1);
        check("rst_full", full_0, 0);
        check("rst_rd_valid", rd_valid_0, 0);
        check("rst_rd_data", rd_data_0, 0);
        check("rst_flags", {ovf_0, unf_0}, 0);

        // Fill: ninth write is dropped and raises overflow
        for (int i = 0; i < 9; i++) begin
            w_inc = 1'b1; wr_data = DW'(8'h11 + i);
            step();
            check("fill_count", count_0, (i < 8) ? i + 1 : 8);
            check("fill_af", af_0, (i >= 5) ? 1 : 0);
            check("fill_full", full_0, (i >= 7) ? 1 : 0);
            check("fill_ovf", ovf_0, (i == 8) ? 1 : 0);
        end
        w_inc = 1'b0;

        // Drain: eight good reads, ninth underflows
        for (int i = 0; i < 9; i++) begin
            r_inc = 1'b1;
            if (i < 8) exp_q.push_back(DW'(8'h11 + i));
            step();
            check("drain_empty", empty_0, (i >= 7) ? 1 : 0);
            check("drain_unf", unf_0, (i == 8) ? 1 : 0);
        end
        r_inc = 1'b0;
        step();
        check("drain_hold_data", rd_data_0, 8'h18);
        check("drain_valid_low", rd_valid_0, 0);

        // Steady state at count 4 with simultaneous read/write
        for (int i = 0; i < 4; i++) begin
            w_inc = 1'b1; wr_data = DW'(8'h20 + i);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            w_inc = 1'b1; r_inc = 1'b1; wr_data = DW'(8'h24 + i);
            exp_q.push_back(DW'(8'h20 + i));
            step();
            check("steady_count", count_0, 4);
        end
        w_inc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r_inc = 1'b1;
            exp_q.push_back(DW'(8'h34 + i));
            step();
        end
        r_inc = 1'b0;
        step();
        check("steady_empty", empty_0, 1);

        // First-word-fall-through instance
        check("fwft_idle_valid", rd_valid_1, 0);
        w_inc = 1'b1; wr_data = 8'hA5;
        step();
        w_inc = 1'b0;
        check("fwft_empty", empty_1, 0);
        check("fwft_valid", rd_valid_1, 1);
        check("fwft_data", rd_data_1, 8'hA5);
        r_inc = 1'b1;
        exp_q.push_back(8'hA5);
        step();
        r_inc = 1'b0;
        check("fwft_empty_after", empty_1, 1);
        check("fwft_valid_after", rd_valid_1, 0);

        // Flush at count 5 with a same-cycle write
        for (int i = 0; i < 5; i++) begin
            w_inc = 1'b1; wr_data = DW'(8'h50 + i);
            step();
        end
        check("preflush_count", count_0, 5);
        flush = 1'b1; w_inc = 1'b1; wr_data = 8'hEE;
        step();
        flush = 1'b0; w_inc = 1'b0;
        check("flush_count", count_0, 0);
        check("flush_empty", empty_0, 1);
        check("flush_ovf_kept", ovf_0, 1);
        check("flush_unf_kept", unf_0, 1);
        check("flush_fwft_valid", rd_valid_1, 0);
        w_inc = 1'b1; wr_data = 8'h60;
        step();
        w_inc = 1'b0; r_inc = 1'b1;
        exp_q.push_back(8'h60);
        step();
        r_inc = 1'b0;
        step();

        // Clear with a same-cycle underflow: the set wins
        err_clr = 1'b1; r_inc = 1'b1;
        step();
        err_clr = 1'b0; r_inc = 1'b0;
        check("clr_ovf", ovf_0, 0);
        check("clr_unf_set_wins", unf_0, 1);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin
            w_inc = 1'b1; wr_data = DW'(8'h70 + i);
            step();
        end
        r_inc = 1'b1; wr_data = 8'h73;
        exp_q.push_back(8'h70);
        step();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_count", count_0, 0);
        check("arst_empty", empty_0, 1);
        check("arst_full", full_0, 0);
        check("arst_rd_valid", rd_valid_0, 0);
        check("arst_flags", {ovf_0, unf_0}, 0);
        check("arst_fwft_valid", rd_valid_1, 0);
        w_inc = 1'b0; r_inc = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
